// File: rtl/cardjitsu_pkg.sv
// cardjitsu_pkg
// Shared types for the Card-Jitsu input front end: element encoding,
// button/action indices, the packed card word and the transaction FSM states.
// A card word is {power[1:0], element[1:0]}, exactly the layout of the sw bank.
package cardjitsu_pkg;

    typedef enum logic [1:0] {
        ELEM_FIRE    = 2'd0,
        ELEM_WATER   = 2'd1,
        ELEM_SNOW    = 2'd2,
        ELEM_ILLEGAL = 2'd3
    } element_e;

    localparam logic [1:0] ACTION_BTN0 = 2'd0;
    localparam logic [1:0] ACTION_BTN1 = 2'd1;
    localparam logic [1:0] ACTION_BTN2 = 2'd2;

    typedef struct packed {
        logic [1:0] power;
        element_e   element;
    } card_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } card_state_e;

    // Fixed priority btn_0 > btn_1 > btn_2; only meaningful when some bit is set.
    function automatic logic [1:0] press_winner(input logic [2:0] press);
        logic [1:0] idx;
        idx = ACTION_BTN0;
        if (press[0])      idx = ACTION_BTN0;
        else if (press[1]) idx = ACTION_BTN1;
        else if (press[2]) idx = ACTION_BTN2;
        return idx;
    endfunction

    // True when two or more buttons pressed on the same cycle.
    function automatic logic multiple_presses(input logic [2:0] press);
        return (press[0] & press[1]) | (press[0] & press[2]) | (press[1] & press[2]);
    endfunction

endpackage

// File: rtl/cardjitsu_debounce.sv
// cardjitsu_debounce
// One push-button channel: 2-flop synchronizer, mismatch counter, debounced
// level flop and a registered one-cycle rise pulse.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   btn_raw      - raw asynchronous button pin (active-high)
//   btn_level    - debounced level
//   btn_press    - high for the one cycle after btn_level rises
module cardjitsu_debounce #(
    parameter int DB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync_meta;
    logic          sync_out;
    logic [CW-1:0] mismatch_cnt;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            sync_out  <= sync_meta;
        end
    end

    // The counter measures how long the synchronized input has disagreed with
    // the debounced level; after DB_CYCLES consecutive disagreeing cycles the
    // level flips. The press pulse is raised on the same edge as a 0->1 flip
    // so it is visible during the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_cnt <= '0;
            btn_level    <= 1'b0;
            btn_press    <= 1'b0;
        end else begin
            btn_press <= 1'b0;
            if (sync_out == btn_level) begin
                mismatch_cnt <= '0;
            end else if (mismatch_cnt == CNT_LAST) begin
                mismatch_cnt <= '0;
                btn_level    <= ~btn_level;
                btn_press    <= ~btn_level;
            end else begin
                mismatch_cnt <= mismatch_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cardjitsu_input_ctrl.sv
// cardjitsu_input_ctrl
// Input front end for the Card-Jitsu core. Debounces three buttons, syncs the
// card switches and turns each accepted press into a card transaction held on
// a valid/ready handshake.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   btn_0, btn_1, btn_2   - raw buttons
//   sw[3:0]               - raw card switches {power, element}
//   btn_level, btn_press  - debounced levels and rise pulses (bit i = btn_i)
//   card_valid/ready      - transaction handshake toward the core
//   card_action           - index of the button that produced the card
//   card_value            - switch value sampled with the press
//   overrun               - pulse: a press was dropped
//   reject                - pulse: a press carried the illegal element
module cardjitsu_input_ctrl
    import cardjitsu_pkg::*;
#(
    parameter int DB_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_0,
    input  logic       btn_1,
    input  logic       btn_2,
    input  logic [3:0] sw,
    output logic [2:0] btn_level,
    output logic [2:0] btn_press,
    output logic       card_valid,
    input  logic       card_ready,
    output logic [1:0] card_action,
    output logic [3:0] card_value,
    output logic       overrun,
    output logic       reject
);

    logic [2:0]  btn_raw;
    logic [3:0]  sw_meta;
    logic [3:0]  sw_sync;
    card_t       cur_card;
    logic        press_any;
    logic        press_multi;
    logic        press_legal;
    logic [1:0]  press_idx;
    card_state_e state;

    assign btn_raw = {btn_2, btn_1, btn_0};

    // Switches are only synchronized, never debounced; they are sampled
    // at the moment of a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_btn
        cardjitsu_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_debounce (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_raw   (btn_raw[i]),
            .btn_level (btn_level[i]),
            .btn_press (btn_press[i])
        );
    end

    assign cur_card    = card_t'(sw_sync);
    assign press_any   = |btn_press;
    assign press_multi = multiple_presses(btn_press);
    assign press_idx   = press_winner(btn_press);
    assign press_legal = press_any && (cur_card.element != ELEM_ILLEGAL);

    // Transaction FSM. Losers of a simultaneous press always overrun; a legal
    // winner is also dropped (overrun) when a card is already held and the core
    // is not taking it this cycle. When the core takes the held card on the
    // same edge a legal press arrives, the new card replaces it with no gap
    // in card_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            card_valid  <= 1'b0;
            card_action <= '0;
            card_value  <= '0;
            overrun     <= 1'b0;
            reject      <= 1'b0;
        end else begin
            overrun <= press_multi;
            reject  <= press_any && !press_legal;
            case (state)
                ST_IDLE: begin
                    if (press_legal) begin
                        state       <= ST_PENDING;
                        card_valid  <= 1'b1;
                        card_action <= press_idx;
                        card_value  <= cur_card;
                    end
                end
                ST_PENDING: begin
                    if (card_ready) begin
                        if (press_legal) begin
                            card_action <= press_idx;
                            card_value  <= cur_card;
                        end else begin
                            state      <= ST_IDLE;
                            card_valid <= 1'b0;
                        end
                    end else if (press_legal) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    card_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/cardjitsu_input_ctrl.md
# cardjitsu_input_ctrl

Input front end for the Card-Jitsu core. Synchronizes and debounces the three push-buttons, synchronizes the 4-bit card switch bank, and converts each accepted button press into a single card-play transaction: the button index plus the switch value at the moment of the press. The transaction is held on a valid/ready handshake toward the game core. This block sits between the board pins (`btn_0..2`, `sw`) and the core's move input.

## Interface
- `DB_CYCLES`, default 1000: consecutive cycles a synchronized button level must differ from its debounced level before the change is accepted. Legal range is ≥2.
- `clk  in  1`: single clock for the block.
- `rst_n  in  1`: asynchronous, active-low reset.
- `btn_0`, `btn_1`, `btn_2`  in  1 each: raw push-buttons, asynchronous, active-high.
- `sw  in  4`: raw card switches, asynchronous. `sw[1:0]` is the element (0 fire, 1 water, 2 snow, 3 illegal). `sw[3:2]` is power.
- `btn_level  out  3`: debounced button levels, with bit i corresponding to btn_i.
- `btn_press  out  3`: one-cycle pulse on each debounced 0→1 transition.
- `card_valid  out  1`: a card transaction is pending.
- `card_ready  in  1`: the core accepts the transaction this cycle.
- `card_action  out  2`: index of the button that produced the card (0..2).
- `card_value  out  4`: `sw` as sampled on the press cycle.
- `overrun  out  1`: one-cycle pulse when a press is dropped.
- `reject  out  1`: one-cycle pulse when a press carries an illegal element.

## Operation
- **Synchronization**
  - Each of `btn_0..2` and `sw[3:0]` passes through a 2-flop synchronizer.
  - `sw` is not debounced. Its synchronized value is sampled directly.
- **Debounce, per button**
  - The counter clears whenever `sync == btn_level`.
  - Otherwise the counter increments each cycle.
  - When the counter reaches `DB_CYCLES-1` and the mismatch persists, `btn_level` toggles and the counter clears.
  - Counter width is `$clog2(DB_CYCLES)`.
  - A glitch shorter than `DB_CYCLES` cycles never toggles `btn_level`.
- **Press pulse**: `btn_press[i]` is registered high for exactly the one cycle following the edge on which `btn_level[i]` rises. Release produces no pulse.
- **Transaction FSM**, with states IDLE and PENDING.
  - IDLE + press with legal element → PENDING. In the same edge, `card_action` and `card_value` are loaded from the press and the synchronized `sw`.
  - IDLE + press with element 3 → stay in IDLE, pulse `reject`.
  - PENDING + `card_ready` → IDLE, unless a legal press occurs in the same cycle. In that case the FSM stays in PENDING and loads the new card, so there is no bubble.
  - PENDING + press without `card_ready` → the press is dropped and `overrun` pulses. The held card is unchanged.
  - An illegal-element press while PENDING raises `reject` only, not `overrun`.
- **Simultaneous presses** (same cycle): priority is btn_0 > btn_1 > btn_2. The winner is processed as above. Each loser is dropped, and `overrun` pulses once for the cycle.
- **Handshake rules**
  - While `card_valid` is high, `card_action` and `card_value` are stable.
  - `card_valid` never drops without `card_ready`.
  - `card_ready` while IDLE is ignored.

## Timing
- **Reset values**: on assertion of `rst_n`, all synchronizer flops, counters, `btn_level`, `btn_press`, `card_valid`, `card_action`, `card_value`, `overrun` and `reject` go to 0 immediately (asynchronously). The FSM goes to IDLE.
- **Reset mid-transaction**: reset while PENDING discards the card. Buttons held through reset release produce a press after full debounce, since the level starts at 0.
- **Latency**: let a button be stable high from the sampling edge E1.
  - `btn_level` rises at edge E1+1+DB_CYCLES.
  - `btn_press` is high for the following cycle.
  - `card_valid` rises one edge after `btn_press` rises.
- **Transfer**: a card transfers on the edge where `card_valid && card_ready`. `card_valid` falls on that edge unless it is reloaded.
- **Illegal element**: `reject` and `overrun` are registered and are coincident with the cycle following the `btn_press` pulse.

## Structure
- **Package `cardjitsu_pkg`**
  - Element encoding: FIRE=0, WATER=1, SNOW=2, ILLEGAL=3.
  - Action index constants.
  - Packed card type: `{power[1:0], element[1:0]}`.
  - FSM state enum.
- **Sub-module `cardjitsu_debounce`**
  - Contains the synchronizer, the counter, the level flop and the rise pulse.
  - Parameterized by `DB_CYCLES`, instantiated three times.
  - The top level holds the `sw` synchronizer, the priority logic and the FSM.

## Test plan
All scenarios run with `DB_CYCLES`=4.
1. `sw`=4'b0110, btn_1 held high 20 cycles, `card_ready`=0 → `btn_press` 3'b010 for one cycle; `card_valid`=1, `card_action`=1, `card_value`=4'h6, held until ready.
2. btn_0 pulsed high 3 cycles, then low → `btn_level`, `btn_press` and `card_valid` stay 0.
3. A card is pending. Press btn_2 while `card_ready`=0 → `overrun` pulses once and the held card is unchanged. Then assert `card_ready` for one cycle → `card_valid` drops next edge.
4. btn_0 and btn_2 rise on the same cycle, `sw`=4'h1 → `card_action`=0 and `overrun` pulses once.
5. `sw`=4'b1011, press btn_1 → `reject` pulses and `card_valid` stays 0.
6. Two scenarios:
   - Pending card with `card_ready` high in the same cycle as a new btn_0 press → `card_valid` stays 1 and the new card is loaded.
   - `rst_n` low mid-PENDING → all outputs 0 immediately.
